clk_div_ctrl: RTL and testbench

- Programmable clock-divider controller. It generates a divided clock, `clk_out`, and a one-cycle `tick` enable from the system clock.
- The division ratio is changed at run time through a req/ack handshake.
- New ratios apply only at a period boundary, so `clk_out` never produces a runt pulse.
- Sits between the control/register logic and the lab datapaths that need slow clocks or enables.

---
 rtl/clk_div_ctrl.sv | 112 +++++++++++
 tb/tb_clk_div_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - programmable clock divider with req/ack ratio change
// Ratio updates land only on a period boundary so clk_out never produces a runt pulse.
module clk_div_ctrl #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             div_req,
  input  logic [WIDTH-1:0] div_val,
  output logic             div_ack,
  output logic             div_err,
  output logic             busy,
  output logic [WIDTH-1:0] cur_div,
  output logic             clk_out,
  output logic             tick
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] next_cnt;
  logic [WIDTH-1:0] half;
  logic             wrap;
  logic             req_ok;
  logic             val_ok;

  assign wrap     = (state != IDLE) && (cnt == cur_div - WIDTH'(1));
  assign next_cnt = wrap ? '0 : cnt + WIDTH'(1);
  assign half     = cur_div >> 1;
  // A request is ignored in its ack cycle so one request yields one ack.
  assign req_ok   = div_req && !div_ack;
  assign val_ok   = div_val > WIDTH'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend    <= '0;
      cur_div <= WIDTH'(DEFAULT_DIV);
      clk_out <= 1'b0;
      tick    <= 1'b0;
      div_ack <= 1'b0;
      div_err <= 1'b0;
      busy    <= 1'b0;
    end else begin
      div_ack <= 1'b0;
      div_err <= 1'b0;
      tick    <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req_ok) begin
            div_ack <= 1'b1;
            if (val_ok) cur_div <= div_val;
            else        div_err <= 1'b1;
          end
          if (en) begin
            state   <= RUN;
            clk_out <= 1'b1;
          end else begin
            clk_out <= 1'b0;
          end
        end
        RUN: begin
          if (req_ok && !val_ok) begin
            div_ack <= 1'b1;
            div_err <= 1'b1;
          end else if (req_ok && (wrap || !en)) begin
            cur_div <= div_val;
            div_ack <= 1'b1;
          end else if (req_ok) begin
            pend  <= div_val;
            busy  <= 1'b1;
            state <= PEND;
          end
          if (!en) begin
            state   <= IDLE;
            cnt     <= '0;
            clk_out <= 1'b0;
          end else begin
            cnt     <= next_cnt;
            clk_out <= next_cnt < half;
            tick    <= wrap;
          end
        end
        PEND: begin
          // The held request is already accepted; div_req/div_val are ignored here.
          if (!en || wrap) begin
            cur_div <= pend;
            div_ack <= 1'b1;
            busy    <= 1'b0;
            state   <= en ? RUN : IDLE;
          end
          if (!en) begin
            cnt     <= '0;
            clk_out <= 1'b0;
          end else begin
            cnt     <= next_cnt;
            clk_out <= next_cnt < half;
            tick    <= wrap;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - randomized bench for clk_div_ctrl against a period-level model
// The model tracks position in period, ratio and an optional pending ratio.
module tb_clk_div_ctrl;
  localparam int W  = 8;
  localparam int DD = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         div_req;
  logic [W-1:0] div_val;
  logic         div_ack, div_err, busy, clk_out, tick;
  logic [W-1:0] cur_div;

  clk_div_ctrl #(.WIDTH(W), .DEFAULT_DIV(DD)) dut (
    .clk(clk), .reset(reset), .en(en), .div_req(div_req), .div_val(div_val),
    .div_ack(div_ack), .div_err(div_err), .busy(busy), .cur_div(cur_div),
    .clk_out(clk_out), .tick(tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_ratio, m_pos, m_pend;
  bit m_run, m_ack, m_err, m_tick;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ratio = DD; m_pos = 0; m_pend = -1;
    m_run = 0; m_ack = 0; m_err = 0; m_tick = 0;
  endtask

  task automatic model_edge(input bit e, input bit rq, input int v);
    bit seen, eop;
    seen = rq && !m_ack;
    eop  = m_run && (m_pos == m_ratio - 1);
    m_ack = 0; m_err = 0; m_tick = 0;
    if (m_pend >= 0) begin
      if (!e || eop) begin
        m_ratio = m_pend; m_pend = -1; m_ack = 1;
      end
      if (!e) begin
        m_run = 0; m_pos = 0;
      end else begin
        m_tick = eop;
        m_pos  = eop ? 0 : m_pos + 1;
      end
    end else begin
      if (seen && v < 2) begin
        m_ack = 1; m_err = 1;
      end else if (seen && (!m_run || !e || eop)) begin
        m_ratio = v; m_ack = 1;
      end else if (seen) begin
        m_pend = v;
      end
      if (m_run && e) begin
        m_tick = eop;
        m_pos  = eop ? 0 : m_pos + 1;
      end else begin
        m_run = e; m_pos = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("clk_out", clk_out, int'(m_run && (m_pos < m_ratio / 2)));
    check("tick",    tick,    int'(m_tick));
    check("div_ack", div_ack, int'(m_ack));
    check("div_err", div_err, int'(m_err));
    check("busy",    busy,    int'(m_pend >= 0));
    check("cur_div", cur_div, m_ratio);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(en, div_req, int'(div_val));
    @(negedge clk);
    compare_all();
    if (m_ack) div_req = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    div_req = 1'b0;
    model_reset();
    #1 compare_all();
    #1 reset = 1'b0;
  endtask

  task automatic req(input int v);
    div_req = 1'b1;
    div_val = W'(v);
    for (int i = 0; i < 300 && div_req; i++) cycle();
    if (div_req) begin
      check("ack_timeout", 0, 1);
      div_req = 1'b0;
    end
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < 300 && m_pos != p; i++) cycle();
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; div_req = 1'b0; div_val = '0;
    model_reset();
    @(negedge clk);
    compare_all();
    reset = 1'b0;

    // Default ratio, then reset in the middle of a run.
    en = 1'b1;
    run(5);
    do_reset();
    run(6);

    // Even ratio programmed from IDLE.
    en = 1'b0;
    run(2);
    req(6);
    check("cur_div_even", cur_div, 6);
    en = 1'b1;
    run(14);

    // Odd ratio, then boundary switch requested at cnt=1.
    req(5);
    run(7);
    wait_pos(1);
    req(4);
    run(8);

    // Invalid ratio, then a request landing exactly on the wrap cycle.
    req(1);
    check("cur_div_kept", cur_div, 4);
    wait_pos(3);
    req(3);
    run(4);

    // Disable while a request is pending.
    wait_pos(0);
    div_req = 1'b1; div_val = W'(7);
    cycle();
    check("busy_pend", busy, 1);
    en = 1'b0;
    cycle();
    check("cur_div_dis", cur_div, 7);
    run(2);

    // Reset while a request is pending.
    en = 1'b1;
    run(3);
    wait_pos(0);
    div_req = 1'b1; div_val = W'(9);
    cycle();
    do_reset();
    check("cur_div_rst", cur_div, DD);
    run(4);

    for (int i = 0; i < 3000; i++) begin
      int r;
      if ($urandom_range(0, 29) == 0) en = ~en;
      if (!div_req && $urandom_range(0, 5) == 0) begin
        div_req = 1'b1;
        r = int'($urandom_range(0, 15));
        div_val = (r == 15) ? W'($urandom_range(0, 63)) : W'(r);
      end else if (m_pend >= 0) begin
        div_val = W'($urandom);
      end
      if ($urandom_range(0, 399) == 0) do_reset();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
